ffd_posedge_en_reg: RTL and testbench
=====================================

Name: ffd_posedge_en_reg

Overview:
- Parameterised, rising-edge D register with load enable and reset.
- Used throughout the core as the basic pipeline/latch element, e.g. the execution unit's latched write-back destination address and its debug source-operand latches.
- Holds its value until enabled; loads D one clock later.

Parameters:
- SIZE, default 32, data width in bits; legal range 1..256. Instances use DATA_ADDRESS_WIDTH and WIDTH (32).
- RESET_VALUE, default 0 (SIZE bits), value forced onto Q by reset.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- Enable  input  1  load enable, sampled on the rising Clock edge.
- D  input  SIZE  data to capture.
- Q  output  SIZE  registered data.
- oUpdated  output  1  load strobe; present only with FFD_UPDATE_STROBE_EN.

Behaviour:
- Reset is asynchronous and active-high. Q = RESET_VALUE immediately on Reset rising, without waiting for Clock. Q is held there for as long as Reset is high, regardless of Clock, Enable or D.
- Reset outputs: Q = RESET_VALUE; oUpdated = 0.
- Release: Reset deassertion is not synchronised inside the block. The first possible load is the first rising Clock edge with Reset low and Enable = 1.
- Normal operation on a rising Clock edge with Reset = 0:
  - Enable = 1: Q <= D.
  - Enable = 0: Q holds its value.
- Latency: D to Q is exactly one clock edge. There is no combinational path from D or Enable to Q.
- Enable is edge-sampled only. Enable pulses between edges have no effect. Changes to D while Enable = 0 never reach Q.
- Back-to-back loads: Enable held high gives Q = D delayed by one cycle, every cycle.
- Reset in mid-operation: a Reset arriving at any time, including coincident with a Clock edge where Enable = 1, wins. Q = RESET_VALUE and the pending load is discarded.
- Widths: D and Q are both SIZE bits, with no extension or truncation. RESET_VALUE is truncated or zero-extended to SIZE.
- No X-propagation masking. If Enable = 1 and D is X, Q becomes X.
- Single always block; no internal state other than Q (and the oUpdated flop when enabled).

Optional Feature:
- Macro: FFD_UPDATE_STROBE_EN.
- Defined:
  - Output oUpdated exists. It is a registered copy of (Enable & ~Reset) taken on each rising Clock edge.
  - It is therefore high for exactly the cycle in which Q shows newly loaded data, and stays high across consecutive loads.
  - It is cleared asynchronously by Reset.
- Not defined: the oUpdated port and its flop are absent; all other behaviour is identical.

Decomposition:
- Shared definitions package holds WIDTH (32), DATA_ADDRESS_WIDTH, DATA_ROW_WIDTH and ROM_ADDRESS_WIDTH, used by instantiators to set SIZE.
- No typedefs are needed.
- No sub-module: the block is a leaf cell.

Test Plan:
- Async reset: SIZE = 8, RESET_VALUE = 8'hA5. Assert Reset between clock edges with Q = 8'h3C → Q = 8'hA5 before the next edge. Toggle Enable = 1, D = 8'hFF with Reset still high → Q stays 8'hA5.
- Load/hold: Reset low, D = 32'h1234_5678, Enable = 1 for one edge → Q = 32'h1234_5678 after that edge. Then Enable = 0, D = 32'hDEAD_BEEF for 5 edges → Q unchanged.
- Streaming: Enable held high, D = 1, 2, 3, 4 on successive cycles → Q = 1, 2, 3, 4, each one cycle later. With FFD_UPDATE_STROBE_EN, oUpdated is high for all 4 cycles, then low.
- Coincident reset: Enable = 1, D = 8'h77, Reset asserted at the same edge → Q = RESET_VALUE and oUpdated = 0.
- Release: deassert Reset, Enable = 0 for 3 edges, then Enable = 1 with D = 8'h42 → Q stays RESET_VALUE until the enabled edge, then becomes 8'h42.
- Width corners: SIZE = 1 with D toggling 0/1 under Enable, and SIZE = 96 with D = all ones then alternating 0xAAAA… → bit-exact capture with no truncation.

Source files
------------

// File: rtl/ffd_posedge_en_reg_pkg.sv
// ============================================================================
// Module : ffd_posedge_en_reg_pkg
// Brief  : Shared width constants used by instantiators of ffd_posedge_en_reg.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ffd_posedge_en_reg_pkg;

  localparam int unsigned WIDTH              = 32;
  localparam int unsigned DATA_ADDRESS_WIDTH = 16;
  localparam int unsigned DATA_ROW_WIDTH     = 16;
  localparam int unsigned ROM_ADDRESS_WIDTH  = 16;

  localparam int unsigned SIZE_MIN = 1;
  localparam int unsigned SIZE_MAX = 256;

  // Legal SIZE range for the register cell.
  function automatic bit size_is_legal(input int unsigned size);
    return (size >= SIZE_MIN) && (size <= SIZE_MAX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ffd_posedge_en_reg_if.sv
// ============================================================================
// Module : ffd_posedge_en_reg_if
// Brief  : Load/data bundle for ffd_posedge_en_reg. oUpdated exists only when
//          FFD_UPDATE_STROBE_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ffd_posedge_en_reg_if
  import ffd_posedge_en_reg_pkg::*;
#(
  parameter int unsigned SIZE = WIDTH
);

  logic            Enable;
  logic [SIZE-1:0] D;
  logic [SIZE-1:0] Q;
`ifdef FFD_UPDATE_STROBE_EN
  logic            oUpdated;
`endif

`ifdef FFD_UPDATE_STROBE_EN
  modport master (output Enable, output D, input  Q, input  oUpdated);
  modport slave  (input  Enable, input  D, output Q, output oUpdated);
`else
  modport master (output Enable, output D, input  Q);
  modport slave  (input  Enable, input  D, output Q);
`endif

endinterface

`default_nettype wire

// File: rtl/ffd_posedge_en_reg.sv
// ============================================================================
// Module : ffd_posedge_en_reg
// Brief  : Rising-edge D register with load enable and async active-high
//          reset. Optional load strobe via macro FFD_UPDATE_STROBE_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ffd_posedge_en_reg
  import ffd_posedge_en_reg_pkg::*;
#(
  parameter int unsigned     SIZE        = WIDTH,
  parameter logic [SIZE-1:0] RESET_VALUE = '0
) (
  input  wire logic            Clock,
  input  wire logic            Reset,
  ffd_posedge_en_reg_if.slave  bus
);

  // Reset is in the sensitivity list, so it wins over a coincident load edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      bus.Q        <= RESET_VALUE;
`ifdef FFD_UPDATE_STROBE_EN
      bus.oUpdated <= 1'b0;
`endif
    end else begin
      if (bus.Enable) begin
        bus.Q <= bus.D;
      end
`ifdef FFD_UPDATE_STROBE_EN
      bus.oUpdated <= bus.Enable;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ffd_posedge_en_reg.sv
// Bench for ffd_posedge_en_reg: four widths (1, 8, 32, 96) sharing Clock/Reset,
// directed scenarios followed by random traffic against a cycle-level model.
`default_nettype none

module tb_ffd_posedge_en_reg;

  localparam logic [0:0]  RV1  = 1'b1;
  localparam logic [7:0]  RV8  = 8'hA5;
  localparam logic [31:0] RV32 = 32'h0;
  localparam logic [95:0] RV96 = 96'h5A5A_0000_FFFF_0000_1234_0001;

  logic Clock;
  logic Reset;

  ffd_posedge_en_reg_if #(.SIZE(1))  if1 ();
  ffd_posedge_en_reg_if #(.SIZE(8))  if8 ();
  ffd_posedge_en_reg_if #(.SIZE(32)) if32 ();
  ffd_posedge_en_reg_if #(.SIZE(96)) if96 ();

  ffd_posedge_en_reg #(.SIZE(1),  .RESET_VALUE(RV1))  u1  (.Clock(Clock), .Reset(Reset), .bus(if1));
  ffd_posedge_en_reg #(.SIZE(8),  .RESET_VALUE(RV8))  u8  (.Clock(Clock), .Reset(Reset), .bus(if8));
  ffd_posedge_en_reg #(.SIZE(32), .RESET_VALUE(RV32)) u32 (.Clock(Clock), .Reset(Reset), .bus(if32));
  ffd_posedge_en_reg #(.SIZE(96), .RESET_VALUE(RV96)) u96 (.Clock(Clock), .Reset(Reset), .bus(if96));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: each register's visible value, stored zero-extended.
  logic [95:0] m_q [4];
  logic        m_u [4];
  logic [3:0]  m_en;
  logic [95:0] m_d;

  function automatic logic [95:0] rv_of(input int i);
    case (i)
      0: return {95'b0, RV1};
      1: return {88'b0, RV8};
      2: return {64'b0, RV32};
      default: return RV96;
    endcase
  endfunction

  function automatic logic [95:0] mask_of(input int i);
    case (i)
      0: return 96'h1;
      1: return 96'hFF;
      2: return 96'hFFFF_FFFF;
      default: return {96{1'b1}};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_q1"},  {95'b0, if1.Q},  m_q[0]);
    chk({tag, "_q8"},  {88'b0, if8.Q},  m_q[1]);
    chk({tag, "_q32"}, {64'b0, if32.Q}, m_q[2]);
    chk({tag, "_q96"}, if96.Q,          m_q[3]);
`ifdef FFD_UPDATE_STROBE_EN
    chk({tag, "_u1"},  {95'b0, if1.oUpdated},  {95'b0, m_u[0]});
    chk({tag, "_u8"},  {95'b0, if8.oUpdated},  {95'b0, m_u[1]});
    chk({tag, "_u32"}, {95'b0, if32.oUpdated}, {95'b0, m_u[2]});
    chk({tag, "_u96"}, {95'b0, if96.oUpdated}, {95'b0, m_u[3]});
`endif
  endtask

  task automatic drive_en(input logic [3:0] en);
    if1.Enable  = en[0];
    if8.Enable  = en[1];
    if32.Enable = en[2];
    if96.Enable = en[3];
  endtask

  task automatic set_in(input logic [3:0] en, input logic [95:0] d);
    drive_en(en);
    if1.D  = d[0];
    if8.D  = d[7:0];
    if32.D = d[31:0];
    if96.D = d;
    m_en = en;
    m_d  = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_q[i] = rv_of(i);
      m_u[i] = 1'b0;
    end
  endtask

  // One rising edge: advance the model from the inputs held across it, then
  // compare on the following falling edge.
  task automatic tick(input string tag);
    @(posedge Clock);
    if (Reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < 4; i++) begin
        m_u[i] = m_en[i];
        if (m_en[i]) m_q[i] = m_d & mask_of(i);
      end
    end
    @(negedge Clock);
    check_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [95:0] rd;
    logic [3:0]  ren;
    Reset = 1'b1;
    set_in(4'h0, '0);
    model_reset();

    // Reset state
    @(negedge Clock);
    check_all("reset");
    @(negedge Clock);
    Reset = 1'b0;
    tick("release_idle");

    // Asynchronous reset between edges, then held against enabled loads
    set_in(4'hF, 96'h3C);
    tick("load_3c");
    #2 Reset = 1'b1;
    model_reset();
    #1 check_all("async_rst");
    set_in(4'hF, {96{1'b1}});
    tick("rst_hold_a");
    tick("rst_hold_b");

    // Release: three idle edges, then a single enabled load
    Reset = 1'b0;
    set_in(4'h0, 96'h42);
    for (int k = 0; k < 3; k++) tick("release_wait");
    set_in(4'hF, 96'h42);
    tick("release_load");

    // Load then hold while D changes
    set_in(4'hF, 96'h1234_5678);
    tick("load");
    set_in(4'h0, 96'hDEAD_BEEF);
    for (int k = 0; k < 5; k++) tick("hold");

    // Streaming 1..4, then drop Enable
    for (int v = 1; v <= 4; v++) begin
      set_in(4'hF, 96'(v));
      tick("stream");
    end
    set_in(4'h0, '0);
    tick("stream_end");

    // Reset coincident with an enabled edge
    set_in(4'hF, 96'h77);
    #5 Reset = 1'b1;
    model_reset();
    @(negedge Clock);
    check_all("coinc_rst");
    Reset = 1'b0;
    set_in(4'h0, '0);
    tick("coinc_after");

    // Width corners
    set_in(4'hF, {96{1'b1}});
    tick("all_ones");
    set_in(4'hF, {24{4'hA}});
    tick("alt_a");
    set_in(4'hF, {24{4'h5}});
    tick("alt_5");
    for (int k = 0; k < 4; k++) begin
      set_in(4'hF, 96'(k & 1));
      tick("toggle");
    end

    // Random traffic with glitches on Enable and mid-cycle reset pulses
    for (int k = 0; k < 300; k++) begin
      ren = 4'($urandom);
      rd  = {$urandom, $urandom, $urandom};
      set_in(ren, rd);
      if ($urandom_range(0, 9) == 0) begin
        #1 drive_en(~ren);
        #1 drive_en(ren);
      end
      if ($urandom_range(0, 15) == 0) begin
        #2 Reset = 1'b1;
        model_reset();
        #1 check_all("rnd_async");
        #1 Reset = 1'b0;
      end
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
